// File: rtl/thermal_pixel_pipe.sv
// Thermal frame buffer to false-colour RGB, nearest-neighbour upscaled.
// Four-cycle pipeline behind vga_gen timing, with double-bank swap on vsync.
module thermal_pixel_pipe #(
    parameter int SRC_W  = 32,
    parameter int SRC_H  = 24,
    parameter int SCALE  = 20,
    parameter int SHIFT  = 4,
    parameter int ADDR_W = $clog2(SRC_W * SRC_H)
) (
    input  logic              i_clk_pixel,
    input  logic              i_rst,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_blank,
    input  logic [9:0]        i_x_pos,
    input  logic [9:0]        i_y_pos,
    input  logic [15:0]       i_t_min,
    output logic [ADDR_W:0]   o_fb_addr,
    output logic              o_fb_rd_en,
    input  logic [15:0]       i_fb_data,
    input  logic              i_frame_ready,
    output logic              o_frame_ack,
    output logic              o_buf_sel,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_blank,
    output logic [7:0]        o_rgb [3]
);

    localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int CW    = 10;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [CW-1:0]    W_LIM    = CW'(SRC_W);
    localparam logic [CW-1:0]    H_LIM    = CW'(SRC_H);

    logic [SUB_W-1:0] r_x_sub, r_y_sub;
    logic [CW-1:0]    r_src_x, r_src_y;
    logic [SUB_W-1:0] w_x_sub, w_y_sub;
    logic [CW-1:0]    w_src_x, w_src_y;
    logic [ADDR_W-1:0] w_lin;
    logic             w_inside;

    logic             r_vs_prev;
    logic             r_pending;
    logic             r_buf_sel;
    logic             r_ack;
    logic             w_swap;

    logic [ADDR_W:0]  r_fb_addr;
    logic             r_fb_rd_en;
    // sideband bundle: {hsync, vsync, blank, inside}
    logic [3:0]       r_sb1, r_sb2, r_sb3;
    logic [7:0]       r_idx;
    logic             r_hs, r_vs, r_bl;
    logic [2:0][7:0]  r_rgb;

    logic [16:0]      w_diff;
    logic [15:0]      w_mag;
    logic [7:0]       w_idx;
    logic [7:0]       w_s;
    logic [2:0][7:0]  w_pal;

    // Counters hold the previous pixel's coordinates; the current ones
    // are derived combinationally so they line up with i_x_pos/i_y_pos.
    always_comb begin
        w_x_sub = '0;
        w_src_x = '0;
        if (i_x_pos != '0) begin
            if (r_x_sub == SUB_LAST) begin
                w_x_sub = '0;
                w_src_x = r_src_x + 1'b1;
            end else begin
                w_x_sub = r_x_sub + 1'b1;
                w_src_x = r_src_x;
            end
        end
    end

    always_comb begin
        w_y_sub = r_y_sub;
        w_src_y = r_src_y;
        if (i_y_pos == '0) begin
            w_y_sub = '0;
            w_src_y = '0;
        end else if (i_x_pos == '0) begin
            if (r_y_sub == SUB_LAST) begin
                w_y_sub = '0;
                w_src_y = r_src_y + 1'b1;
            end else begin
                w_y_sub = r_y_sub + 1'b1;
            end
        end
    end

    assign w_inside = (w_src_x < W_LIM) && (w_src_y < H_LIM);
    assign w_lin    = ADDR_W'(w_src_y * SRC_W + w_src_x);

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_x_sub <= '0;
            r_src_x <= '0;
            r_y_sub <= '0;
            r_src_y <= '0;
        end else begin
            r_x_sub <= w_x_sub;
            r_src_x <= w_src_x;
            r_y_sub <= w_y_sub;
            r_src_y <= w_src_y;
        end
    end

    // A ready arriving on the same cycle as the vsync edge still swaps.
    assign w_swap = r_vs_prev & ~i_vsync & (r_pending | i_frame_ready);

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_vs_prev <= 1'b1;
            r_pending <= 1'b0;
            r_buf_sel <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_vs_prev <= i_vsync;
            r_ack     <= w_swap;
            if (w_swap) begin
                r_buf_sel <= ~r_buf_sel;
                r_pending <= 1'b0;
            end else if (i_frame_ready) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_diff = {1'b0, i_fb_data} - {1'b0, i_t_min};
    assign w_mag  = w_diff[15:0] >> SHIFT;

    always_comb begin
        w_idx = w_mag[7:0];
        if (w_diff[16]) begin
            w_idx = 8'd0;
        end else if (|w_mag[15:8]) begin
            w_idx = 8'hFF;
        end
    end

    always_comb begin
        w_s   = {r_idx[5:0], 2'b00};
        w_pal = '0;
        unique case (r_idx[7:6])
            2'd0: w_pal = {8'd0,   8'd0,   w_s};
            2'd1: w_pal = {w_s,    8'd0,   ~w_s};
            2'd2: w_pal = {8'hFF,  w_s,    8'd0};
            2'd3: w_pal = {8'hFF,  8'hFF,  w_s};
        endcase
    end

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_fb_addr  <= '0;
            r_fb_rd_en <= 1'b0;
            r_sb1      <= 4'b1110;
            r_sb2      <= 4'b1110;
            r_sb3      <= 4'b1110;
            r_idx      <= '0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_bl       <= 1'b1;
            r_rgb      <= '0;
        end else begin
            r_fb_addr  <= {r_buf_sel, w_lin};
            r_fb_rd_en <= ~i_blank;
            r_sb1      <= {i_hsync, i_vsync, i_blank, w_inside};
            r_sb2      <= r_sb1;
            r_sb3      <= r_sb2;
            r_idx      <= w_idx;
            r_hs       <= r_sb3[3];
            r_vs       <= r_sb3[2];
            r_bl       <= r_sb3[1];
            if (r_sb3[1] || !r_sb3[0]) begin
                r_rgb <= '0;
            end else begin
                r_rgb <= w_pal;
            end
        end
    end

    assign o_fb_addr   = r_fb_addr;
    assign o_fb_rd_en  = r_fb_rd_en;
    assign o_frame_ack = r_ack;
    assign o_buf_sel   = r_buf_sel;
    assign o_hsync     = r_hs;
    assign o_vsync     = r_vs;
    assign o_blank     = r_bl;
    assign o_rgb[2]    = r_rgb[2];
    assign o_rgb[1]    = r_rgb[1];
    assign o_rgb[0]    = r_rgb[0];

endmodule
